// File: rtl/param_fetch_seq.sv
// param_fetch_seq: walks layer weight/bias indices and streams beats through a credit-gated FIFO.
// Define PARAM_SEQ_PERF_EN to add the stall_cnt performance counter port.
module param_fetch_seq #(
  parameter int LAT   = 1,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   layer,
  output logic         busy,
  output logic         done,
  output logic [3:0]   mem_state,
  output logic         w_en,
  output logic [6:0]   read_o,
  output logic [5:0]   read_c,
  output logic [7:0]   read_i,
  input  logic [143:0] conv_w,
  input  logic [127:0] dense_w,
  input  logic [15:0]  bias,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [143:0] out_w,
  output logic [15:0]  out_bias,
  output logic [6:0]   out_o,
  output logic         out_first,
  output logic         out_last
`ifdef PARAM_SEQ_PERF_EN
  ,
  output logic [15:0]  stall_cnt
`endif
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_DRAIN, S_DONE
  } state_t;

  typedef struct packed {
    logic [6:0]  o;
    logic        first;
    logic        last;
    logic [15:0] bias;
  } tag_t;

  typedef struct packed {
    logic [143:0] w;
    logic [15:0]  bias;
    logic [6:0]   o;
    logic         first;
    logic         last;
  } beat_t;

  state_t         state_q, state_d;
  logic [3:0]     layer_q, layer_d;
  logic [6:0]     o_q, o_d, o_max;
  logic [5:0]     n_q, n_d, n_max;
  logic [LAT-1:0] vld_q;
  tag_t           tag_q [LAT];
  tag_t           tag_in;
  beat_t          mem_q [DEPTH];
  beat_t          beat_in, beat_out;
  logic [AW-1:0]  wr_q, rd_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [7:0]     infl, infl_nx;
  logic           layer_ok, is_dense, credit;
  logic           issue, push, pop, n_last, o_last;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // o_max / n_max are the last index values, not counts
  always_comb begin
    o_max = '0;
    n_max = '0;
    unique case (layer_q)
      4'b0010: begin o_max = 7'd15; n_max = 6'd0;  end
      4'b0100: begin o_max = 7'd31; n_max = 6'd15; end
      4'b0110: begin o_max = 7'd63; n_max = 6'd31; end
      4'b1000: begin o_max = 7'd95; n_max = 6'd31; end
      4'b1001: begin o_max = 7'd95; n_max = 6'd11; end
      default: ;
    endcase
  end

  assign layer_ok = layer inside {4'b0010, 4'b0100, 4'b0110, 4'b1000, 4'b1001};
  assign is_dense = layer_q[3];
  assign n_last   = (n_q == n_max);
  assign o_last   = (o_q == o_max);

  always_comb begin
    infl = '0;
    for (int k = 0; k < LAT; k++) infl = infl + 8'(vld_q[k]);
  end

  assign credit  = (8'(cnt_q) + infl) < 8'(DEPTH);
  assign issue   = (state_q == S_RUN) && credit;
  assign push    = vld_q[LAT-1];
  assign pop     = out_valid && out_ready;
  assign cnt_d   = cnt_q + CW'(push) - CW'(pop);
  assign infl_nx = infl - 8'(push);

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    o_d     = o_q;
    n_d     = n_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = layer_ok ? S_RUN : S_DONE;
          layer_d = layer_ok ? layer : 4'b0000;
        end
      end
      S_RUN: begin
        if (issue) begin
          n_d = n_last ? '0 : n_q + 6'd1;
          if (n_last) o_d = o_last ? '0 : o_q + 7'd1;
          if (n_last && o_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (infl_nx == 8'd0 && cnt_d == '0) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        layer_d = 4'b0000;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tag_in = '{o: o_q, first: (n_q == 6'd0), last: n_last, bias: bias};

  always_comb begin
    beat_in       = '0;
    beat_in.w     = is_dense ? {16'h0000, dense_w} : conv_w;
    beat_in.bias  = tag_q[LAT-1].bias;
    beat_in.o     = tag_q[LAT-1].o;
    beat_in.first = tag_q[LAT-1].first;
    beat_in.last  = tag_q[LAT-1].last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      layer_q <= '0;
      o_q     <= '0;
      n_q     <= '0;
      vld_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      layer_q  <= layer_d;
      o_q      <= o_d;
      n_q      <= n_d;
      vld_q[0] <= issue;
      for (int k = 1; k < LAT; k++) vld_q[k] <= vld_q[k-1];
      if (push) wr_q <= ptr_inc(wr_q);
      if (pop)  rd_q <= ptr_inc(rd_q);
      cnt_q <= cnt_d;
    end
  end

  // payload storage needs no reset; valid bits and pointers qualify it
  always_ff @(posedge clk) begin
    if (issue) tag_q[0] <= tag_in;
    for (int k = 1; k < LAT; k++) tag_q[k] <= tag_q[k-1];
    if (push) mem_q[wr_q] <= beat_in;
  end

`ifdef PARAM_SEQ_PERF_EN
  logic [15:0] stall_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      stall_q <= '0;
    end else if (state_q == S_RUN && !credit && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end
  assign stall_cnt = stall_q;
`endif

  assign beat_out  = mem_q[rd_q];
  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign mem_state = busy ? layer_q : 4'b0000;
  assign w_en      = issue;
  assign read_o    = o_q;
  assign read_c    = is_dense ? 6'd0 : n_q;
  assign read_i    = is_dense ? {n_q[4:0], 3'b000} : 8'd0;
  assign out_valid = (cnt_q != '0);
  assign out_w     = beat_out.w;
  assign out_bias  = beat_out.bias;
  assign out_o     = beat_out.o;
  assign out_first = beat_out.first;
  assign out_last  = beat_out.last;

endmodule

// File: tb/tb_param_fetch_seq.sv
// Scoreboard bench for param_fetch_seq: expected beats queued at start, monitor pops on handshake.
// Memory model returns index-encoded weights one cycle after w_en.
module tb_param_fetch_seq;
  logic         clk = 1'b0;
  logic         rst, start, out_ready;
  logic [3:0]   layer;
  logic         busy, done, w_en, out_valid, out_first, out_last;
  logic [3:0]   mem_state;
  logic [6:0]   read_o, out_o;
  logic [5:0]   read_c;
  logic [7:0]   read_i;
  logic [143:0] conv_w = '0;
  logic [127:0] dense_w = '0;
  logic [15:0]  bias, out_bias;
  logic [143:0] out_w;
`ifdef PARAM_SEQ_PERF_EN
  logic [15:0]  stall_cnt;
`endif

  param_fetch_seq dut (
    .clk(clk), .rst(rst), .start(start), .layer(layer),
    .busy(busy), .done(done), .mem_state(mem_state), .w_en(w_en),
    .read_o(read_o), .read_c(read_c), .read_i(read_i),
    .conv_w(conv_w), .dense_w(dense_w), .bias(bias),
    .out_valid(out_valid), .out_ready(out_ready), .out_w(out_w),
    .out_bias(out_bias), .out_o(out_o), .out_first(out_first),
    .out_last(out_last)
`ifdef PARAM_SEQ_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [143:0] w;
    logic [15:0]  b;
    logic [6:0]   o;
    logic         f;
    logic         l;
  } exp_t;

  exp_t sb[$];
  int total = 0, bad = 0;
  int cyc = 0, mode = 0;
  int first_wen, first_vld, first_pop, last_pop, done_cyc;
  int pops, wen_cnt, done_cnt, ri_bad;
  bit held = 0;
  logic [168:0] hold_v;
  logic [168:0] cur;

  function automatic logic [143:0] cw(input logic [6:0] o, input logic [5:0] c);
    return {9{o, c, 3'b101}};
  endfunction

  function automatic logic [127:0] dw(input logic [6:0] o, input logic [7:0] i);
    return {8{1'b1, o, i}};
  endfunction

  assign bias = {4'hB, 5'd0, read_o};
  assign cur  = {out_w, out_bias, out_o, out_first, out_last};

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (w_en) begin
      conv_w  <= cw(read_o, read_c);
      dense_w <= dw(read_o, read_i);
    end
  end

  task automatic chk(input bit ok, input string nm,
                     input logic [191:0] a, input logic [191:0] e);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  task automatic dims(input logic [3:0] code, output int no, output int ni);
    case (code)
      4'b0010: begin no = 16; ni = 1;  end
      4'b0100: begin no = 32; ni = 16; end
      4'b0110: begin no = 64; ni = 32; end
      4'b1000: begin no = 96; ni = 32; end
      4'b1001: begin no = 96; ni = 12; end
      default: begin no = 0;  ni = 0;  end
    endcase
  endtask

  task automatic push_exp(input logic [3:0] code);
    int no, ni;
    exp_t e;
    dims(code, no, ni);
    for (int o = 0; o < no; o++) begin
      for (int n = 0; n < ni; n++) begin
        e.w = code[3] ? {16'h0000, dw(7'(o), 8'(n * 8))} : cw(7'(o), 6'(n));
        e.b = {4'hB, 5'd0, 7'(o)};
        e.o = 7'(o);
        e.f = (n == 0);
        e.l = (n == ni - 1);
        sb.push_back(e);
      end
    end
  endtask

  task automatic clear_stats();
    first_wen = -1; first_vld = -1; first_pop = -1;
    last_pop = -1; done_cyc = -1;
    pops = 0; wen_cnt = 0; done_cnt = 0; ri_bad = 0;
  endtask

  // monitor: scoreboard pops, stall stability, event timestamps
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      held = 0;
    end else begin
      if (w_en) begin
        wen_cnt++;
        if (first_wen < 0) first_wen = cyc;
        if (read_i[2:0] != 3'b000) ri_bad++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (held && out_valid) chk(cur == hold_v, "stall hold", cur, hold_v);
      if (out_valid && first_vld < 0) first_vld = cyc;
      if (out_valid && out_ready) begin
        pops++;
        last_pop = cyc;
        if (first_pop < 0) first_pop = cyc;
        if (sb.size() == 0) begin
          chk(1'b0, "extra beat", cur, 0);
        end else begin
          e = sb.pop_front();
          chk(cur == e, "beat", cur, e);
        end
      end
      held   = out_valid && !out_ready;
      hold_v = cur;
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic run(input logic [3:0] code, input int tmo,
                     input bit extra, input bit hold);
    int t0, n, no, ni;
    bit seen;
    dims(code, no, ni);
    clear_stats();
    push_exp(code);
    @(posedge clk); #1 start = 1'b1; layer = code;
    @(posedge clk); #1 start = 1'b0; layer = 4'b0000;
    t0 = cyc;
    if (extra) begin
      repeat (2) @(posedge clk);
      #1 start = 1'b1; layer = 4'b1001;
      @(posedge clk); #1 start = 1'b0; layer = 4'b0000;
      @(negedge clk);
      chk(busy && mem_state == code, "start ignored while busy", mem_state, code);
    end
    if (hold) begin
      repeat (40) @(negedge clk);
      mode = 2;
      @(posedge clk); #2;
      n = 0;
      repeat (20) begin
        @(negedge clk);
        if (w_en) n++;
      end
      chk(n <= 4, "issues under stall", n, 4);
      chk(!w_en, "w_en low under stall", w_en, 0);
      mode = 0;
    end
    seen = 0;
    for (int k = 0; k < tmo && !seen; k++) begin
      @(negedge clk);
      seen = done;
    end
    #1;
    chk(seen, "done timeout", seen, 1);
    chk(pops == no * ni, "beat count", pops, no * ni);
    chk(sb.size() == 0, "beats missing", sb.size(), 0);
    if (extra) begin
      chk(first_wen == t0, "first w_en cycle", first_wen, t0);
      chk(first_vld == t0 + 2, "first out_valid cycle", first_vld, t0 + 2);
      chk(done_cyc == last_pop + 1, "done after last pop", done_cyc, last_pop + 1);
    end
    if (code == 4'b1001) begin
      chk(last_pop - first_pop == no * ni - 1, "one beat per cycle",
          last_pop - first_pop, no * ni - 1);
      chk(ri_bad == 0, "read_i alignment", ri_bad, 0);
    end
    @(negedge clk);
    chk(!done && !busy, "done pulse width", {busy, done}, 0);
    chk(done_cnt == 1, "done count", done_cnt, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; layer = 4'b0000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk({busy, done, w_en, out_valid, mem_state, read_o, read_c, read_i} == '0,
        "reset state", {busy, done, w_en, out_valid, mem_state, read_o, read_c, read_i}, 0);

    mode = 0; run(4'b0010, 200, 1'b1, 1'b0);
    mode = 1; run(4'b0100, 5000, 1'b0, 1'b0);
    mode = 0; run(4'b0110, 5000, 1'b0, 1'b1);
    mode = 0; run(4'b1001, 3000, 1'b0, 1'b0);

    clear_stats();
    push_exp(4'b1000);
    @(posedge clk); #1 start = 1'b1; layer = 4'b1000;
    @(posedge clk); #1 start = 1'b0; layer = 4'b0000;
    repeat (50) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    sb.delete();
    done_cnt = 0;
    @(negedge clk);
    chk(!busy && !out_valid && !done && mem_state == 4'b0000, "abort by reset",
        {busy, out_valid, done, mem_state}, 0);
    repeat (5) @(negedge clk);
    chk(done_cnt == 0, "no done after abort", done_cnt, 0);
    mode = 0; run(4'b0010, 200, 1'b0, 1'b0);

    clear_stats();
    @(posedge clk); #1 start = 1'b1; layer = 4'b0000;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk(done && !busy, "invalid layer done", {busy, done}, 1);
    @(negedge clk);
    chk(!done, "invalid layer pulse", done, 0);
    chk(wen_cnt == 0, "invalid layer no reads", wen_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
